// File: rtl/jacobi_pkg.sv
// Shared definitions for the Jacobi eigen flow datapath blocks.
//   N_DIM / WORD_W / IDX_W : matrix order, element width, row-index width
//   ACC_W                  : signed accumulator width for a full row dot product
//   state_e                : row-dot engine FSM states
//   sat_word()             : clamp a Q32.32-derived value to a signed 32-bit word
package jacobi_pkg;

  localparam int unsigned N_DIM  = 32;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned ACC_W  = 69;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [WORD_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [WORD_W-1:0] SAT_MIN = 32'h8000_0000;

  // Saturation limits sign-extended to accumulator width.
  localparam logic signed [ACC_W-1:0] ACC_SAT_MAX =
    {{(ACC_W-WORD_W+1){1'b0}}, {(WORD_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_SAT_MIN =
    {{(ACC_W-WORD_W+1){1'b1}}, {(WORD_W-1){1'b0}}};

  function automatic logic [WORD_W-1:0] sat_word(input logic signed [ACC_W-1:0] v);
    if (v > ACC_SAT_MAX)      sat_word = SAT_MAX;
    else if (v < ACC_SAT_MIN) sat_word = SAT_MIN;
    else                      sat_word = v[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/aat_lane_sum.sv
// Combinational multiply/add over one group of element pairs.
//   a_i, b_i : LANES packed signed 32-bit elements (element 0 in the low word)
//   sum_o    : sign-extended sum of the LANES full 64-bit products
module aat_lane_sum
  import jacobi_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic [LANES*WORD_W-1:0]  a_i,
  input  logic [LANES*WORD_W-1:0]  b_i,
  output logic signed [ACC_W-1:0]  sum_o
);

  logic signed [WORD_W-1:0]   ea;
  logic signed [WORD_W-1:0]   eb;
  logic signed [2*WORD_W-1:0] prod;

  always_comb begin
    sum_o = '0;
    ea    = '0;
    eb    = '0;
    prod  = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      ea    = a_i[k*WORD_W +: WORD_W];
      eb    = b_i[k*WORD_W +: WORD_W];
      prod  = ea * eb;
      sum_o = sum_o + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/aat_row_dot.sv
// Row-pair dot-product engine for the A*A^T stage.
// Accepts a pair of 32-element signed Q16.16 rows with their (i, j) tag,
// accumulates LANES products per cycle, and presents the saturated Q16.16
// dot product with its tag until the consumer takes it.
//   clk, reset           : clock, asynchronous active-high reset
//   row_1, row_2         : input rows, element k at bits [32k+31:32k]
//   in_i, in_j           : row indices of the pair
//   in_valid / in_ready  : input handshake (ready only while idle)
//   dot_out              : saturated result, valid with out_valid
//   out_i, out_j         : tag of the result
//   out_valid / out_ready: output handshake
module aat_row_dot
  import jacobi_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned FRAC  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_DIM*WORD_W-1:0] row_1,
  input  logic [N_DIM*WORD_W-1:0] row_2,
  input  logic [IDX_W-1:0]        in_i,
  input  logic [IDX_W-1:0]        in_j,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WORD_W-1:0]       dot_out,
  output logic [IDX_W-1:0]        out_i,
  output logic [IDX_W-1:0]        out_j,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned   GRP_N    = N_DIM / LANES;
  localparam logic [4:0]    GRP_LAST = 5'(GRP_N - 1);
  localparam int unsigned   GRP_BITS = LANES * WORD_W;

  state_e                   state_q, state_d;
  logic [4:0]               grp_q, grp_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [N_DIM*WORD_W-1:0]  r1_q, r1_d;
  logic [N_DIM*WORD_W-1:0]  r2_q, r2_d;
  logic [IDX_W-1:0]         i_q, i_d;
  logic [IDX_W-1:0]         j_q, j_d;

  logic signed [ACC_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  shifted;

  // The row registers shift down one group per MAC cycle, so the current
  // group always sits in the low bits; grp_q only tracks progress.
  aat_lane_sum #(.LANES(LANES)) u_lane_sum (
    .a_i   (r1_q[GRP_BITS-1:0]),
    .b_i   (r2_q[GRP_BITS-1:0]),
    .sum_o (lane_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grp_q   <= '0;
      acc_q   <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      acc_q   <= acc_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    acc_d   = acc_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          r1_d    = row_1;
          r2_d    = row_2;
          i_d     = in_i;
          j_d     = in_j;
          acc_d   = '0;
          grp_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + lane_sum;
        r1_d  = r1_q >> GRP_BITS;
        r2_d  = r2_q >> GRP_BITS;
        if (grp_q == GRP_LAST) begin
          state_d = S_DONE;
        end else begin
          grp_d = grp_q + 5'd1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_i     = i_q;
  assign out_j     = j_q;

  // Arithmetic shift floors toward -inf before clamping to 32 bits.
  assign shifted = acc_q >>> FRAC;
  assign dot_out = sat_word(shifted);

endmodule

// File: tb/tb_aat_row_dot.sv
module tb_aat_row_dot;

  logic           clk = 1'b0;
  logic           reset;
  logic [1023:0]  row_1, row_2;
  logic [4:0]     in_i, in_j;
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    dot_out;
  logic [4:0]     out_i, out_j;
  logic           out_valid;
  logic           out_ready;

  int unsigned errors = 0;
  int unsigned checks = 0;

  aat_row_dot #(.LANES(4), .FRAC(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_1     (row_1),
    .row_2     (row_2),
    .in_i      (in_i),
    .in_j      (in_j),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dot_out   (dot_out),
    .out_i     (out_i),
    .out_j     (out_j),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // mode 0: every element a/b; mode 1: element 0 only; mode 2: row_1[k]=(k+1)<<16, row_2[k]=b
  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    int unsigned mode;
    logic [4:0]  i;
    logic [4:0]  j;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_rows(input vec_t v);
    for (int k = 0; k < 32; k++) begin
      case (v.mode)
        1:       begin row_1[k*32 +: 32] = (k == 0) ? v.a : 32'h0;
                       row_2[k*32 +: 32] = (k == 0) ? v.b : 32'h0; end
        2:       begin row_1[k*32 +: 32] = 32'(k + 1) << 16;
                       row_2[k*32 +: 32] = v.b; end
        default: begin row_1[k*32 +: 32] = v.a;
                       row_2[k*32 +: 32] = v.b; end
      endcase
    end
    in_i = v.i;
    in_j = v.j;
  endtask

  // Presents a pair while idle; returns after the accept edge (+1).
  task automatic accept(input vec_t v);
    set_rows(v);
    chk({v.name, "/in_ready_before"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({v.name, "/in_ready_after"}, {31'b0, in_ready}, 32'd0);
  endtask

  // Counts edges until out_valid, bounded; returns the count (99 on timeout).
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) n = 99;
  endtask

  task automatic take_result(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "/out_valid_after_hs"}, {31'b0, out_valid}, 32'd0);
    chk({name, "/in_ready_after_hs"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    accept(v);
    wait_valid(n);
    chk({v.name, "/latency"}, 32'(n), 32'd8);
    chk({v.name, "/dot_out"}, dot_out, v.exp);
    chk({v.name, "/out_i"}, {27'b0, out_i}, {27'b0, v.i});
    chk({v.name, "/out_j"}, {27'b0, out_j}, {27'b0, v.j});
    take_result(v.name);
  endtask

  initial begin
    int n;
    logic [31:0] held_dot;

    tbl[0] = '{"unit",      32'h0001_0000, 32'h0001_0000, 0, 5'd3,  5'd7,  32'h0020_0000};
    tbl[1] = '{"signed",    32'hFFFE_0000, 32'h0000_8000, 0, 5'd1,  5'd2,  32'hFFE0_0000};
    tbl[2] = '{"sat_pos",   32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 5'd31, 5'd31, 32'h7FFF_FFFF};
    tbl[3] = '{"sat_neg",   32'h8000_0000, 32'h7FFF_FFFF, 0, 5'd0,  5'd31, 32'h8000_0000};
    tbl[4] = '{"trunc_pos", 32'h0000_0001, 32'h0000_0001, 1, 5'd4,  5'd5,  32'h0000_0000};
    tbl[5] = '{"trunc_neg", 32'hFFFF_FFFF, 32'h0000_0001, 1, 5'd6,  5'd9,  32'hFFFF_FFFF};
    tbl[6] = '{"ramp_x1",   32'h0,         32'h0001_0000, 2, 5'd10, 5'd20, 32'h0210_0000};
    tbl[7] = '{"ramp_xm2",  32'h0,         32'hFFFE_0000, 2, 5'd17, 5'd30, 32'hFBE0_0000};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    row_1 = '0; row_2 = '0; in_i = '0; in_j = '0;
    #12;
    chk("rst/in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst/out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst/dot_out",   dot_out,            32'd0);
    chk("rst/out_i",     {27'b0, out_i},     32'd0);
    chk("rst/out_j",     {27'b0, out_j},     32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 8; t++) run_vec(tbl[t]);

    // Backpressure: second pair driven while the first result is held.
    accept(tbl[0]);
    wait_valid(n);
    chk("bp/latency", 32'(n), 32'd8);
    held_dot = dot_out;
    chk("bp/dot_first", held_dot, 32'h0020_0000);
    set_rows(tbl[1]);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp/out_valid_hold", {31'b0, out_valid}, 32'd1);
      chk("bp/dot_stable", dot_out, held_dot);
      chk("bp/out_i_stable", {27'b0, out_i}, 32'd3);
      chk("bp/out_j_stable", {27'b0, out_j}, 32'd7);
      chk("bp/in_ready_low", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp/idle_after_hs", {31'b0, in_ready}, 32'd1);
    chk("bp/not_done", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp/accepted_next", {31'b0, in_ready}, 32'd0);
    wait_valid(n);
    chk("bp/latency2", 32'(n), 32'd8);
    chk("bp/dot_second", dot_out, 32'hFFE0_0000);
    chk("bp/out_i2", {27'b0, out_i}, 32'd1);
    chk("bp/out_j2", {27'b0, out_j}, 32'd2);
    take_result("bp");

    // Reset during the 3rd MAC cycle.
    accept(tbl[2]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #3;
    chk("rstmid/out_valid", {31'b0, out_valid}, 32'd0);
    chk("rstmid/dot_out",   dot_out,            32'd0);
    chk("rstmid/in_ready",  {31'b0, in_ready},  32'd1);
    chk("rstmid/out_i",     {27'b0, out_i},     32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rstmid/still_idle", {31'b0, in_ready}, 32'd1);
    run_vec(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aat_row_dot.md
# aat_row_dot

Row-pair dot-product engine for the A·Aᵀ stage of the Jacobi eigen flow. It sits directly downstream of the row fetcher that presents `row_1`/`row_2` (32 × 32-bit elements, 1024 bits each). For each accepted row pair (i, j) it computes the signed Q16.16 dot product S[i][j] = Σ A[i][k]·A[j][k]. It returns the saturated 32-bit result, tagged with (i, j), for the symmetric-matrix writer.

## Interface
Parameters:
- `LANES`, 4: multipliers per cycle; legal values 1, 2, 4, 8, 16, 32.
- `FRAC`, 16: fractional bits of the element format.

Ports:
- `clk` in 1: single clock; rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `row_1` in 1024: row i; element k = bits [32k+31:32k], signed Q16.16.
- `row_2` in 1024: row j; same format.
- `in_i` in 5: row index i.
- `in_j` in 5: row index j.
- `in_valid` in 1: row pair and indices are valid.
- `in_ready` out 1: block can accept a pair; reset value 1.
- `dot_out` out 32: saturated result, signed Q16.16; reset value 0.
- `out_i` out 5: index i of the result; reset value 0.
- `out_j` out 5: index j of the result; reset value 0.
- `out_valid` out 1: result valid; reset value 0.
- `out_ready` in 1: consumer takes the result.

## Operation
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, the block latches `row_1`, `row_2`, `in_i`, `in_j`, clears the accumulator, sets `grp`=0 and moves to MAC.
- MAC:
  - Each cycle, the block adds the products of elements k = grp·LANES … grp·LANES+LANES−1 into the accumulator. Each product is a full 64-bit signed product.
  - When grp = 32/LANES−1, the block moves to DONE. Otherwise grp increments.
  - Input changes during MAC are ignored because the rows are held in internal registers.
- DONE:
  - `out_valid`=1.
  - `dot_out`, `out_i` and `out_j` are stable.
  - On `out_ready`, the block moves to IDLE.
- `in_ready` is 1 only in IDLE. `out_valid` is 1 only in DONE.
- Arithmetic:
  - The accumulator is 69-bit signed (32 × 2^62 needs 68 bits, plus 1 bit of margin). It holds the raw Q32.32 sum.
  - Result = accumulator arithmetically shifted right by FRAC, which truncates toward −∞.
  - The result saturates to the range [0x80000000, 0x7FFFFFFF].
  - `dot_out` is taken from the accumulator register and is meaningful only while `out_valid`=1.
- Reset:
  - Asserting reset at any time, including mid-MAC or in DONE, forces IDLE immediately.
  - It also clears the accumulator, grp, the tag registers and `out_valid`.
  - An in-flight result is discarded.

## Timing
- Accept edge E0 → MAC.
- Edges E1…E(32/LANES) accumulate; the last of these edges enters DONE.
- `out_valid` is high after 32/LANES edges following acceptance: 8 edges for LANES=4, 32 edges for LANES=1.
- With `out_ready` held high, the handshake edge is E(32/LANES+1). The next accept is possible at E(32/LANES+2).
- Throughput is one result per 32/LANES+2 cycles (10 cycles for LANES=4).
- Backpressure: DONE holds indefinitely with all outputs stable. No new pair is accepted.
- `in_valid` dropping before acceptance has no effect. There is no combinational path from `out_ready` to `in_ready`.

## Structure
- Shared package `jacobi_pkg` holds:
  - `N_DIM`=32
  - `WORD_W`=32
  - `IDX_W`=5
  - `ACC_W`=69
  - the state enum
  - the saturation limits
- Sub-module `aat_lane_sum` is a combinational block that multiplies LANES element pairs and sums the products to ACC_W bits.
- `aat_row_dot` contains the FSM, the row registers, group selection, the accumulator and the shift/saturate logic.

## Test plan
Scenarios 1–6 use LANES=4.

1. **Unit values:** all elements of both rows = 0x00010000, i=3, j=7 → `dot_out`=0x00200000, `out_i`=3, `out_j`=7. `out_valid` rises exactly 8 edges after acceptance.
2. **Signed values:** row_1 elements = 0xFFFE0000 (−2.0), row_2 elements = 0x00008000 (0.5) → `dot_out`=0xFFE00000 (−32.0).
3. **Saturation:**
   - All 0x7FFFFFFF × 0x7FFFFFFF → 0x7FFFFFFF.
   - All 0x80000000 × 0x7FFFFFFF → 0x80000000.
4. **Truncation:**
   - Element 0 = 0x00000001 × 0x00000001, others 0 → 0x00000000.
   - Element 0 = 0xFFFFFFFF × 0x00000001, others 0 → 0xFFFFFFFF.
5. **Backpressure:** `out_ready`=0 for 5 cycles after `out_valid` while a second pair is driven with `in_valid`=1:
   - `dot_out`, `out_i` and `out_j` stay stable.
   - `in_ready`=0 throughout.
   - The second pair is accepted only on the cycle after the handshake.
6. **Reset mid-operation:** assert `reset` during the 3rd MAC cycle for 3 ns:
   - `out_valid`=0, `dot_out`=0 and `in_ready`=1 immediately.
   - The next pair (scenario 1 data) produces 0x00200000 with normal latency.
